gen_pipe_skid_pipe: RTL
=======================

Name: gen_pipe_skid_pipe

Overview:
- Parametrised multi-stage pipeline register with a valid/ready handshake, per-stage skid buffering, synchronous flush to a bubble value, and a global stall.
- Generalises the single hold/default-load flop used between core pipeline stages (IF/ID/EX/MEM) to arbitrary width and depth with full backpressure.
- Sustains 1 transfer/cycle with registered in_ready, so there is no combinational ready path across stages.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 1, number of cascaded skid stages; legal range 1..8. Values outside the range cause an elaboration error.
- BUBBLE, {DW{1'b0}}, value loaded into data registers on reset/flush and when a stage drains to empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous flush; all stages empty, data = BUBBLE.
- stall_i  in  1  freeze; no state or data change, handshakes masked.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  pipe can accept in_data this cycle.
- in_data  in  DW  upstream data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  head-of-pipe data.
- occ_o  out  $clog2(2*DEPTH+1)  total entries held across all stages.

Behaviour:
- Priority at each rising edge: rst==0 > flush_i > stall_i > normal operation.
- Reset (rst==0) and flush: every stage goes to EMPTY, main and skid regs = BUBBLE, occ_o = 0.
  - Resulting outputs: out_valid=0, out_data=BUBBLE, in_ready=1 (once rst is high and flush_i is low).
  - in_valid coinciding with flush is dropped.
- Per-stage state in {EMPTY, FULL, SKID}. Each stage holds a main reg (drives that stage's out) and a skid reg.
- EMPTY:
  - in_valid: main <= in, go to FULL.
  - Otherwise stay in EMPTY.
- FULL:
  - in_valid & out_ready: main <= in, stay in FULL.
  - in_valid & !out_ready: skid <= in, go to SKID.
  - !in_valid & out_ready: main <= BUBBLE, go to EMPTY.
  - Neither: hold.
- SKID:
  - out_ready: main <= skid, skid <= BUBBLE, go to FULL. in_valid is ignored because in_ready=0 in this state.
  - !out_ready: hold.
- Stage outputs:
  - in_ready = (state != SKID) & !stall_i & !flush_i. Combinational only from state and the global controls.
  - out_valid = (state != EMPTY) & !stall_i & !flush_i.
  - out_data = main reg, unconditionally.
- Transfer happens only when valid & ready are both high in the same cycle. Data are never duplicated or lost except on flush/reset.
- Stall: all registers hold their values. Masked handshakes guarantee no transfer occurs at either end.
- Chain: stage k out connects to stage k+1 in; flush_i and stall_i are broadcast to all stages. Pipe in_* connects to stage 0; out_* connects to stage DEPTH-1.
- Latency: an accepted input appears on out_valid exactly DEPTH cycles later when out_ready has been held high. Throughput is 1 per cycle.
- Capacity: 2*DEPTH entries. in_ready deasserts only when stage 0 is in SKID.
- occ_o: +1 on pipe input transfer, -1 on pipe output transfer, unchanged when both happen in the same cycle. It is registered and saturates at neither end. Reaching a value outside 0..2*DEPTH is an assertion failure.
- Order: strict FIFO across the whole pipe.

Decomposition:
- Shared package gen_pipe_pkg:
  - State encodings: ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKID=2'b10. 2'b11 is illegal and recovers to ST_EMPTY.
  - DEPTH_MAX = 8.
- One sub-module, gen_pipe_skid_stage (DW, BUBBLE): implements a single stage. The top generates DEPTH instances and owns the occ_o counter.

Test Plan:
- Reset, DW=32, DEPTH=2, BUBBLE=32'hDEAD_BEEF: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=32'hDEADBEEF, occ_o=0. The first cycle after release has in_ready=1.
- Streaming, DEPTH=2, out_ready=1: push 1,2,3 on consecutive cycles -> out_data 1,2,3 on out_valid at cycles 2,3,4 after the first accept. occ_o peaks at 2.
- Backpressure, DEPTH=1, out_ready=0: push A,B -> in_ready=0 after B, occ_o=2. Then out_ready=1 -> A then B are emitted on consecutive cycles, with in_ready=1 again the cycle after A leaves.
- Fill and drain, DEPTH=3, out_ready=0: push 6 words -> in_ready=0, occ_o=6. Then drain -> words emitted in order, occ_o=0, out_data=BUBBLE.
- Flush mid-stream, DEPTH=2: 3 entries held, assert flush_i for 1 cycle with in_valid=1 and data 0x55 -> next cycle occ_o=0, out_valid=0, and 0x55 is never emitted.
- Stall with simultaneous handshakes: stall_i=1 for 4 cycles while in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, occ_o unchanged. After release the original data sequence resumes with no loss.

Source files
------------

// File: rtl/gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen_pipe_pkg
// Purpose  : Shared definitions for the generic skid-buffered pipeline.
//            - state_t   : per-stage occupancy state (EMPTY / FULL / SKID)
//            - DEPTH_MAX : largest supported number of cascaded stages
// Revision : 1.0 - initial release
// ============================================================================
package gen_pipe_pkg;

    // 2'b11 is not a legal encoding; stages recover from it to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    localparam int DEPTH_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/gen_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : gen_pipe_skid_stage
// Purpose  : One valid/ready pipeline stage with a main register and a skid
//            register. in_ready is derived from the stage state and the
//            global controls only, so there is no ready path through the
//            stage.
// Ports    : clk, rst (sync, active-low)
//            flush_i   - empty the stage, registers load BUBBLE
//            stall_i   - freeze the stage, handshakes masked
//            in_valid / in_ready / in_data    - upstream side
//            out_valid / out_ready / out_data - downstream side
// Revision : 1.0 - initial release
// ============================================================================
module gen_pipe_skid_stage
    import gen_pipe_pkg::*;
#(
    parameter int            DW     = 32,
    parameter logic [DW-1:0] BUBBLE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          w_live;
    logic          w_in_fire;
    logic          w_out_fire;

    // Stall and flush mask both handshakes, so neither side can transfer
    // while the pipe is frozen or being cleared.
    assign w_live     = !stall_i && !flush_i;
    assign in_ready   = (r_state != ST_SKID)  && w_live;
    assign out_valid  = (r_state != ST_EMPTY) && w_live;
    assign out_data   = r_main;
    assign w_in_fire  = in_valid  && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data;
                end else if (w_in_fire) begin
                    // Downstream is blocked: park the new word behind main.
                    w_skid_nxt  = in_data;
                    w_state_nxt = ST_SKID;
                end else if (w_out_fire) begin
                    w_main_nxt  = BUBBLE;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_fire) begin
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = BUBBLE;
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_main_nxt  = BUBBLE;
                w_skid_nxt  = BUBBLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gen_pipe_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gen_pipe_skid_pipe
// Purpose  : DEPTH cascaded skid stages forming a full-throughput pipeline
//            register with backpressure, synchronous flush and global stall.
//            Also tracks the total number of held entries.
// Ports    : clk, rst (sync, active-low)
//            flush_i, stall_i            - broadcast to every stage
//            in_valid / in_ready / in_data    - feeds stage 0
//            out_valid / out_ready / out_data - from stage DEPTH-1
//            occ_o                       - entries held, 0..2*DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module gen_pipe_skid_pipe
    import gen_pipe_pkg::*;
#(
    parameter int            DW     = 32,
    parameter int            DEPTH  = 1,
    parameter logic [DW-1:0] BUBBLE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           stall_i,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DW-1:0]                  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DW-1:0]                  out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]   occ_o
);

    localparam int OCC_W   = $clog2(2*DEPTH+1);
    localparam int OCC_MAX = 2*DEPTH;

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("gen_pipe_skid_pipe: DEPTH=%0d outside 1..%0d", DEPTH, DEPTH_MAX);
    end

    // Index k is the input side of stage k; index DEPTH is the pipe output.
    logic [DEPTH:0]         w_valid;
    logic [DEPTH:0]         w_ready;
    logic [DEPTH:0][DW-1:0] w_data;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign in_ready       = w_ready[0];
    assign out_valid      = w_valid[DEPTH];
    assign out_data       = w_data[DEPTH];
    assign w_ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        gen_pipe_skid_stage #(
            .DW     (DW),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush_i),
            .stall_i   (stall_i),
            .in_valid  (w_valid[k]),
            .in_ready  (w_ready[k]),
            .in_data   (w_data[k]),
            .out_valid (w_valid[k+1]),
            .out_ready (w_ready[k+1]),
            .out_data  (w_data[k+1])
        );
    end

    // Occupancy: counts pipe-level transfers only; a simultaneous push and
    // pop cancel out. Masked handshakes make stall a natural hold.
    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    assign w_push = in_valid  && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign occ_o  = r_occ;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            r_occ <= '0;
        end else if (w_push && !w_pop) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_push && w_pop) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    // Any wrap past either end lands above OCC_MAX, so one bound suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (int'(r_occ) <= OCC_MAX);
        end
    end

endmodule
`default_nettype wire
